// File: rtl/mdu_iter.sv
// mdu_iter: iterative 32-bit multiply/divide unit (MULTU/MULT/DIVU/DIV).
// The unit takes 32 shift-add or restoring-divide steps on operand magnitudes; sign fix-up happens in FIX.
module mdu_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, a_q, hi_q, lo_q;
  logic        is_div_q, neg_q, sa_q, bz_q, busy_q, done_q, dz_q;
  logic [31:0] mag_a, mag_b, quo, rem;
  logic [32:0] mul_sum, shl;
  logic [33:0] trial;
  logic [63:0] prod;
  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    mag_a   = (op[0] && a[31]) ? -a : a;
    mag_b   = (op[0] && b[31]) ? -b : b;
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    shl     = acc_q[63:31];
    trial   = {1'b0, shl} - {2'b00, opnd_q};
    acc_d   = !is_div_q ? {mul_sum, acc_q[31:1]} :
              trial[33] ? {shl[31:0], acc_q[30:0], 1'b0} : {trial[31:0], acc_q[30:0], 1'b1};
    prod    = neg_q ? -acc_q : acc_q;
    quo     = neg_q ? -acc_q[31:0] : acc_q[31:0];
    rem     = sa_q ? -acc_q[63:32] : acc_q[63:32];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      bz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          is_div_q <= op[1];
          neg_q    <= op[0] & (a[31] ^ b[31]);
          sa_q     <= op[0] & a[31];
          bz_q     <= (b == 32'd0);
          a_q      <= a;
          opnd_q   <= op[1] ? mag_b : mag_a;
          acc_q    <= {32'd0, op[1] ? mag_a : mag_b};
          cnt_q    <= '0;
          busy_q   <= 1'b1;
          state_q  <= CALC;
        end
        CALC: begin
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + 5'd1;
          state_q <= (cnt_q == 5'd31) ? FIX : CALC;
        end
        FIX: begin
          hi_q    <= !is_div_q ? prod[63:32] : bz_q ? a_q : rem;
          lo_q    <= !is_div_q ? prod[31:0] : bz_q ? 32'hFFFF_FFFF : quo;
          dz_q    <= is_div_q & bz_q;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: table vectors, random ops against an arithmetic model, and reset/start-collision sequences.
module tb_mdu_iter;
  logic        clk, rst_n, start, busy, done, div_zero;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;
  int tests = 0, fails = 0;

  mdu_iter dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
                .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Plain language arithmetic: 64-bit products, truncating signed division
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el, output logic ed);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ed = 1'b0;
    if (o == 2'b00) begin
      p = {32'd0, x} * {32'd0, y};
      eh = p[63:32]; el = p[31:0];
    end else if (o == 2'b01) begin
      p = 64'(sx * sy);
      eh = p[63:32]; el = p[31:0];
    end else if (y == 32'd0) begin
      eh = x; el = 32'hFFFF_FFFF; ed = 1'b1;
    end else if (o == 2'b10) begin
      eh = x % y; el = x / y;
    end else begin
      q = sx / sy; r = sx % sy;
      eh = 32'(r); el = 32'(q);
    end
  endtask

  // Called at a negedge; returns at a negedge one cycle after done
  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input bit poke, input string nm);
    logic [31:0] eh, el;
    logic ed;
    int lat;
    model(o, x, y, eh, el, ed);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    chk({nm, " busy"}, 64'(busy), 64'd1);
    lat = 0;
    for (int k = 2; k <= 40; k++) begin
      if (poke && k == 11) begin
        start = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom);
      end else start = 1'b0;
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    chk({nm, " latency"}, 64'(lat), 64'd34);
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
    chk({nm, " div_zero"}, 64'(div_zero), 64'(ed));
    @(negedge clk);
    chk({nm, " done_pulse"}, {62'd0, done, busy}, 64'd0);
    chk({nm, " hold"}, {hi, lo}, {eh, el});
  endtask

  initial begin
    tbl[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[1] = '{2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    tbl[2] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[3] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    tbl[4] = '{2'b10, 32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF, 1'b1};
    tbl[5] = '{2'b00, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0};
    tbl[6] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    tbl[7] = '{2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    tbl[8] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    #1;
    chk("reset_state", {29'd0, busy, done, div_zero, hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // first start accepted at the first edge after release
    for (int i = 0; i < 9; i++) begin
      logic [31:0] eh, el;
      logic ed;
      model(tbl[i].op, tbl[i].a, tbl[i].b, eh, el, ed);
      chk($sformatf("model_tbl%0d", i), {ed, eh, el}, {tbl[i].dz, tbl[i].hi, tbl[i].lo});
      run(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, $sformatf("tbl%0d", i));
    end
    run(2'b10, 32'd100, 32'd7, 1'b1, "ignored_start");
    // start presented only on the DONE->IDLE edge must not be taken
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= 40 && !done; k++) @(negedge clk);
    chk("collide_done", 64'(done), 64'd1);
    start = 1'b1; a = 32'd11; b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    chk("collide_busy0", 64'(busy), 64'd0);
    @(negedge clk);
    chk("collide_busy1", {62'd0, busy, done}, 64'd0);
    chk("collide_result", 64'(lo), 64'd45);
    // mid-operation asynchronous reset
    start = 1'b1; op = 2'b00; a = 32'h0001_0001; b = 32'h0003_0003;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {29'd0, busy, done, div_zero, hi, lo}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("reset_no_done", {62'd0, busy, done}, 64'd0);
    end
    rst_n = 1'b1;
    run(2'b00, 32'd1234, 32'd5678, 1'b0, "after_reset");
    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 3) == 0) y = -y;
      run(2'($urandom), x, y, 1'($urandom), $sformatf("rand%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
